// File: rtl/red_pitaya_mixer_pkg.sv
// Shared constants for the Red Pitaya mixer block: register map, sample
// width, saturation limits and CTRL/STATUS bit positions.
package red_pitaya_mixer_pkg;

  localparam int DATA_W  = 14;
  localparam int SAT_MAX = 8191;
  localparam int SAT_MIN = -8192;

  localparam logic [15:0] ADDR_CTRL        = 16'h0100;
  localparam logic [15:0] ADDR_STATUS      = 16'h0104;
  localparam logic [15:0] ADDR_RAMP_DIV    = 16'h0108;
  localparam logic [15:0] ADDR_RAMP_STEP   = 16'h010C;
  localparam logic [15:0] ADDR_TARGET_BASE = 16'h0110;
  localparam logic [15:0] ADDR_CUR_BASE    = 16'h0140;
  localparam logic [15:0] ADDR_SHIFT       = 16'h0200;
  localparam logic [15:0] ADDR_NCH         = 16'h0204;
  localparam logic [15:0] ADDR_GAINBITS    = 16'h020C;

  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_RAMP_EN_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_SAT_BIT   = 1;

  typedef struct packed {
    logic ramp_en;
    logic enable;
  } ctrl_t;

  // Address of per-channel slot k inside a 4-byte-strided bank.
  function automatic logic [15:0] slot_addr(input logic [15:0] base, input int k);
    return base + 16'(4 * k);
  endfunction

endpackage

// File: rtl/red_pitaya_gain_ramp.sv
// One channel's gain register pair: a bus-written target gain and the
// current gain that follows it, either at once or in bounded steps on ticks.
module red_pitaya_gain_ramp
  import red_pitaya_mixer_pkg::*;
#(
  parameter int GAINBITS = 24
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                tick,
  input  logic                ramp_en,
  input  logic [GAINBITS-2:0] step,
  input  logic                target_we,
  input  logic [GAINBITS-1:0] target_wdata,
  output logic [GAINBITS-1:0] target,
  output logic [GAINBITS-1:0] cur_gain
);

  logic signed [GAINBITS:0] diff;
  logic        [GAINBITS:0] mag;
  logic        [GAINBITS:0] step_ext;
  logic        [GAINBITS-1:0] stepped;
  logic                     ramp_active;

  // Distance to target at one extra bit so opposite-sign gains cannot wrap.
  always_comb begin
    diff        = $signed({target[GAINBITS-1], target}) - $signed({cur_gain[GAINBITS-1], cur_gain});
    mag         = diff[GAINBITS] ? -diff : diff;
    step_ext    = {2'b00, step};
    stepped     = diff[GAINBITS] ? (cur_gain - {1'b0, step}) : (cur_gain + {1'b0, step});
    ramp_active = ramp_en && (step != '0);
  end

  // Target register; a new target mid-ramp simply redirects from cur_gain.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      target <= '0;
    end else if (target_we) begin
      target <= target_wdata;
    end
  end

  // Current gain: follows target directly, or steps toward it on ticks and snaps when close.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cur_gain <= '0;
    end else if (!ramp_active) begin
      cur_gain <= target;
    end else if (tick) begin
      if (mag <= step_ext) begin
        cur_gain <= target;
      end else begin
        cur_gain <= stepped;
      end
    end
  end

endmodule

// File: rtl/red_pitaya_mixer_block.sv
// Weighted-sum mixer: NCH signed 14-bit inputs times ramped signed gains,
// summed, scaled by 2^-SHIFT and saturated to 14 bits, with a register bus.
module red_pitaya_mixer_block
  import red_pitaya_mixer_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int GAINBITS = 24,
  parameter int SHIFT    = 12,
  parameter int DIVBITS  = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [NCH*14-1:0]   dat_i,
  output logic [13:0]         dat_o,
  output logic                sat_o,
  input  logic [15:0]         addr,
  input  logic                wen,
  input  logic                ren,
  input  logic [31:0]         wdata,
  output logic                ack,
  output logic [31:0]         rdata
);

  localparam int PW   = DATA_W + GAINBITS;
  localparam int SUMW = PW + 2;
  localparam logic signed [SUMW-1:0] MAXV = SUMW'(SAT_MAX);
  localparam logic signed [SUMW-1:0] MINV = SUMW'(SAT_MIN);

  ctrl_t               ctrl;
  logic [DIVBITS-1:0]  ramp_div;
  logic [GAINBITS-2:0] ramp_step;
  logic [DIVBITS-1:0]  div_cnt;
  logic                tick;
  logic                sat_sticky;
  logic                ramp_busy;
  logic [NCH-1:0]      target_we;
  logic                ctrl_we, status_we, div_we, step_we;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  logic [GAINBITS-1:0]        target_q [NCH];
  logic [GAINBITS-1:0]        cur_q    [NCH];
  logic signed [DATA_W-1:0]   dat_r    [NCH];
  logic signed [GAINBITS-1:0] gain_r   [NCH];
  logic signed [PW-1:0]       prod_r   [NCH];

  logic signed [SUMW-1:0] sum;
  logic signed [SUMW-1:0] shifted;
  logic [13:0]            res_d;
  logic                   sat_d;

  assign unused_wdata = ^wdata;

  // Write-strobe decode for every writable register.
  always_comb begin
    ctrl_we   = wen && (addr == ADDR_CTRL);
    status_we = wen && (addr == ADDR_STATUS);
    div_we    = wen && (addr == ADDR_RAMP_DIV);
    step_we   = wen && (addr == ADDR_RAMP_STEP);
    target_we = '0;
    for (int k = 0; k < NCH; k++) begin
      target_we[k] = wen && (addr == slot_addr(ADDR_TARGET_BASE, k));
    end
  end

  // Control and ramp configuration registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctrl      <= '0;
      ramp_div  <= '0;
      ramp_step <= '0;
    end else begin
      if (ctrl_we) begin
        ctrl.enable  <= wdata[CTRL_ENABLE_BIT];
        ctrl.ramp_en <= wdata[CTRL_RAMP_EN_BIT];
      end
      if (div_we)  ramp_div  <= wdata[DIVBITS-1:0];
      if (step_we) ramp_step <= wdata[GAINBITS-2:0];
    end
  end

  assign tick = (div_cnt >= ramp_div);

  // Shared ramp divider: wraps after reaching RAMP_DIV, restarts on a divider write.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_cnt <= '0;
    end else if (div_we || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIVBITS'(1);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    red_pitaya_gain_ramp #(
      .GAINBITS(GAINBITS)
    ) u_ramp (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .tick        (tick),
      .ramp_en     (ctrl.ramp_en),
      .step        (ramp_step),
      .target_we   (target_we[k]),
      .target_wdata(wdata[GAINBITS-1:0]),
      .target      (target_q[k]),
      .cur_gain    (cur_q[k])
    );
  end

  // Busy while any channel's current gain has not yet arrived at its target.
  always_comb begin
    ramp_busy = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (cur_q[k] != target_q[k]) ramp_busy = 1'b1;
    end
  end

  // Sticky saturation flag; a fresh saturation beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sat_sticky <= 1'b0;
    end else if (sat_o) begin
      sat_sticky <= 1'b1;
    end else if (status_we && wdata[STATUS_SAT_BIT]) begin
      sat_sticky <= 1'b0;
    end
  end

  // Read multiplexer; unmapped addresses and absent channel slots fall through to 0.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_CTRL: begin
        rd_mux[CTRL_ENABLE_BIT]  = ctrl.enable;
        rd_mux[CTRL_RAMP_EN_BIT] = ctrl.ramp_en;
      end
      ADDR_STATUS: begin
        rd_mux[STATUS_BUSY_BIT] = ramp_busy;
        rd_mux[STATUS_SAT_BIT]  = sat_sticky;
      end
      ADDR_RAMP_DIV:  rd_mux = 32'(ramp_div);
      ADDR_RAMP_STEP: rd_mux = 32'(ramp_step);
      ADDR_SHIFT:     rd_mux = 32'(SHIFT);
      ADDR_NCH:       rd_mux = 32'(NCH);
      ADDR_GAINBITS:  rd_mux = 32'(GAINBITS);
      default:        rd_mux = '0;
    endcase
    for (int k = 0; k < NCH; k++) begin
      if (addr == slot_addr(ADDR_TARGET_BASE, k))
        rd_mux = {{(32-GAINBITS){target_q[k][GAINBITS-1]}}, target_q[k]};
      if (addr == slot_addr(ADDR_CUR_BASE, k))
        rd_mux = {{(32-GAINBITS){cur_q[k][GAINBITS-1]}}, cur_q[k]};
    end
  end

  // Bus response: every strobe is acknowledged one cycle later with registered data.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= wen | ren;
      rdata <= ren ? rd_mux : '0;
    end
  end

  // Pipeline stages 1 and 2: capture samples and gains, then form the products.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NCH; k++) begin
        dat_r[k]  <= '0;
        gain_r[k] <= '0;
        prod_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        dat_r[k]  <= dat_i[14*k +: 14];
        gain_r[k] <= cur_q[k];
        prod_r[k] <= PW'(dat_r[k]) * PW'(gain_r[k]);
      end
    end
  end

  // Stage 3 combinational: widened sum, floor shift, clip to the 14-bit range.
  always_comb begin
    sum = '0;
    for (int k = 0; k < NCH; k++) begin
      sum = sum + SUMW'(prod_r[k]);
    end
    shifted = sum >>> SHIFT;
    res_d   = shifted[13:0];
    sat_d   = 1'b0;
    if (!ctrl.enable) begin
      res_d = '0;
    end else if (shifted > MAXV) begin
      res_d = 14'(SAT_MAX);
      sat_d = 1'b1;
    end else if (shifted < MINV) begin
      res_d = 14'(SAT_MIN);
      sat_d = 1'b1;
    end
  end

  // Stage 3 register driving the outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dat_o <= '0;
      sat_o <= 1'b0;
    end else begin
      dat_o <= res_d;
      sat_o <= sat_d;
    end
  end

endmodule

// File: tb/tb_red_pitaya_mixer_block.sv
// Self-checking bench for red_pitaya_mixer_block (NCH=2, GAINBITS=24, SHIFT=12).
module tb_red_pitaya_mixer_block;

  localparam int NCH      = 2;
  localparam int GAINBITS = 24;
  localparam int SHIFT    = 12;
  localparam int DIVBITS  = 16;

  localparam logic [15:0] A_CTRL    = 16'h0100;
  localparam logic [15:0] A_STATUS  = 16'h0104;
  localparam logic [15:0] A_DIV     = 16'h0108;
  localparam logic [15:0] A_STEP    = 16'h010C;
  localparam logic [15:0] A_TGT0    = 16'h0110;
  localparam logic [15:0] A_TGT1    = 16'h0114;
  localparam logic [15:0] A_CUR0    = 16'h0140;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [27:0] dat_i;
  logic [13:0] dat_o;
  logic        sat_o;
  logic [15:0] addr;
  logic        wen;
  logic        ren;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  longint exp_g0, exp_g1;
  bit     exp_en;
  logic [14:0] sb_q [$];

  logic [31:0] chg_val [$];
  int          chg_cyc [$];
  logic [31:0] start_val;
  int          ack_missing;

  red_pitaya_mixer_block #(
    .NCH(NCH), .GAINBITS(GAINBITS), .SHIFT(SHIFT), .DIVBITS(DIVBITS)
  ) dut (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .dat_i (dat_i),
    .dat_o (dat_o),
    .sat_o (sat_o),
    .addr  (addr),
    .wen   (wen),
    .ren   (ren),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Reference output {sat, dat} for one input pair under the current gains.
  function automatic logic [14:0] model_out(input int d0, input int d1);
    longint s, sh;
    logic [13:0] r;
    logic sf;
    if (!exp_en) return 15'd0;
    s  = longint'(d0) * exp_g0 + longint'(d1) * exp_g1;
    sh = s >>> SHIFT;
    if (sh > 8191) begin
      r = 14'h1FFF; sf = 1'b1;
    end else if (sh < -8192) begin
      r = 14'h2000; sf = 1'b1;
    end else begin
      r = sh[13:0]; sf = 1'b0;
    end
    return {sf, r};
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk_i);
    addr = a; wdata = d; wen = 1'b1;
    @(negedge clk_i);
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic got_ack);
    @(negedge clk_i);
    addr = a; ren = 1'b1;
    @(negedge clk_i);
    ren = 1'b0;
    got_ack = ack;
    d = rdata;
  endtask

  task automatic set_gains(input int g0, input int g1, input bit en);
    bus_write(A_CTRL, {31'd0, en});
    bus_write(A_TGT0, 32'(g0));
    bus_write(A_TGT1, 32'(g1));
    repeat (4) @(negedge clk_i);
    exp_g0 = g0; exp_g1 = g1; exp_en = en;
  endtask

  // Streams CUR_GAIN[0] reads every cycle, logging each change; entered at a negedge.
  task automatic watch_cur0(input int n, input logic [31:0] stop_val);
    logic [31:0] last;
    chg_val.delete(); chg_cyc.delete(); ack_missing = 0;
    addr = A_CUR0; ren = 1'b1;
    last = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (ack !== 1'b1) ack_missing++;
      if (i == 0) begin
        start_val = rdata; last = rdata;
      end else if (rdata !== last) begin
        chg_val.push_back(rdata); chg_cyc.push_back(i); last = rdata;
      end
      if (rdata === stop_val) break;
    end
    ren = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic a;
    rstn_i = 1'b0; dat_i = '0; addr = '0; wen = 1'b0; ren = 1'b0; wdata = '0;
    #1;
    n_checks++;
    if ({dat_o, sat_o, ack, rdata} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: dat_o=%0h sat_o=%0b ack=%0b rdata=%0h, expected all 0", dat_o, sat_o, ack, rdata);
    end
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    bus_read(A_CTRL, d, a);
    n_checks++;
    if (a !== 1'b1 || d !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_ctrl: ack=%0b rdata=%0h, expected ack=1 rdata=0", a, d); end
    bus_read(16'h0200, d, a);
    n_checks++;
    if (d !== 32'd12) begin n_fail++; $display("[TB] FAIL const_shift: rdata=%0d, expected 12", d); end
    bus_read(16'h020C, d, a);
    n_checks++;
    if (d !== 32'd24) begin n_fail++; $display("[TB] FAIL const_gainbits: rdata=%0d, expected 24", d); end
  endtask

  // Datapath stream: expected results queued at drive time, popped 3 cycles later.
  task automatic test_datapath(input string name, input int mode, input int n);
    int d0, d1;
    logic [14:0] e, got;
    sb_q.delete();
    d0 = 0; d1 = 0;
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk_i);
      if (i >= 3) begin
        e = sb_q.pop_front();
        got = {sat_o, dat_o};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("[TB] FAIL %s[%0d]: dat_o=%0d sat_o=%0b, expected dat_o=%0d sat_o=%0b",
                   name, i - 3, $signed(got[13:0]), got[14], $signed(e[13:0]), e[14]);
        end
      end
      if (i < n) begin
        case (mode)
          0: begin
            case (i)
              0: d0 = 1000;  1: d0 = -1000; 2: d0 = 0;     3: d0 = 1;
              4: d0 = -1;    5: d0 = 8191;  6: d0 = -8192; default: d0 = int'($urandom_range(16383)) - 8192;
            endcase
            d1 = int'($urandom_range(16383)) - 8192;
          end
          1: begin d0 = 8000;  d1 = 8000;  end
          2: begin d0 = -8000; d1 = -8000; end
          default: begin
            d0 = int'($urandom_range(16383)) - 8192;
            d1 = int'($urandom_range(16383)) - 8192;
          end
        endcase
        dat_i = {14'(d1), 14'(d0)};
        sb_q.push_back(model_out(d0, d1));
      end
    end
  endtask

  task automatic test_pass_through();
    set_gains(32'h001000, 0, 1'b1);
    test_datapath("pass_through", 0, 12);
  endtask

  task automatic test_saturation();
    logic [31:0] d; logic a;
    set_gains(32'h001000, 32'h001000, 1'b1);
    test_datapath("sat_pos", 1, 5);
    test_datapath("sat_neg", 2, 5);
    bus_read(A_STATUS, d, a);
    n_checks++;
    if (d[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_sticky_set: STATUS=%0h, expected bit1=1", d); end
    bus_write(A_STATUS, 32'h2);
    bus_read(A_STATUS, d, a);
    n_checks++;
    if (d[1] !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_sticky_hold: STATUS=%0h, expected bit1=1", d); end
    dat_i = '0;
    repeat (5) @(negedge clk_i);
    bus_write(A_STATUS, 32'h2);
    bus_read(A_STATUS, d, a);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL sat_sticky_clear: STATUS=%0h, expected 0", d); end
  endtask

  task automatic test_weighted_sum();
    set_gains(32'h000800, -32'h000C00, 1'b1);
    test_datapath("weighted_random", 3, 24);
  endtask

  task automatic test_enable_off();
    set_gains(32'h001000, 32'h001000, 1'b0);
    test_datapath("enable_off", 1, 6);
  endtask

  task automatic test_ramp();
    logic [31:0] d; logic a;
    int bad_val, bad_gap;
    set_gains(0, 0, 1'b1);
    bus_write(A_STEP, 32'h100);
    bus_write(A_DIV, 32'd9);
    bus_write(A_CTRL, 32'h3);
    bus_write(A_TGT0, 32'h001000);
    watch_cur0(200, 32'h001000);
    bad_val = 0; bad_gap = 0;
    foreach (chg_val[j]) begin
      if (chg_val[j] !== 32'(32'h100 * (j + 1))) bad_val++;
      if (j > 0 && (chg_cyc[j] - chg_cyc[j-1]) != 10) bad_gap++;
    end
    n_checks++;
    if (start_val !== 32'd0 || chg_val.size() != 16 || ack_missing != 0) begin
      n_fail++;
      $display("[TB] FAIL ramp_steps: start=%0h changes=%0d ack_missing=%0d, expected start=0 changes=16 ack_missing=0",
               start_val, chg_val.size(), ack_missing);
    end
    n_checks++;
    if (bad_val != 0 || bad_gap != 0) begin
      n_fail++;
      $display("[TB] FAIL ramp_profile: bad_values=%0d bad_spacing=%0d, expected 0x100 steps every 10 cycles", bad_val, bad_gap);
    end
    bus_read(A_STATUS, d, a);
    n_checks++;
    if (d[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL ramp_busy_clear: STATUS=%0h, expected bit0=0", d); end
  endtask

  task automatic test_no_overshoot();
    bus_write(A_CTRL, 32'h1);
    bus_write(A_TGT0, 32'h0);
    repeat (4) @(negedge clk_i);
    bus_write(A_CTRL, 32'h3);
    bus_write(A_TGT0, 32'h150);
    watch_cur0(40, 32'h150);
    n_checks++;
    if (start_val !== 32'd0 || chg_val.size() != 2 || chg_val[0] !== 32'h100 || chg_val[1] !== 32'h150) begin
      n_fail++;
      $display("[TB] FAIL no_overshoot: start=%0h changes=%0d last=%0h, expected 0 -> 100 -> 150",
               start_val, chg_val.size(), (chg_val.size() > 0) ? chg_val[chg_val.size()-1] : 32'hX);
    end
    bus_write(A_CTRL, 32'h1);
    bus_write(A_TGT0, 32'h0);
    repeat (4) @(negedge clk_i);
    bus_write(A_CTRL, 32'h3);
    bus_write(A_TGT0, 32'h001000);
    watch_cur0(30, 32'h100);
    n_checks++;
    if (chg_val.size() != 1 || chg_val[0] !== 32'h100) begin
      n_fail++;
      $display("[TB] FAIL redirect_pre: changes=%0d, expected a single step to 100", chg_val.size());
    end
    bus_write(A_TGT0, 32'hFFFFFE00);
    @(negedge clk_i);
    watch_cur0(50, 32'hFFFFFE00);
    n_checks++;
    if (start_val !== 32'h100 || chg_val.size() != 3 || chg_val[0] !== 32'h0 ||
        chg_val[1] !== 32'hFFFFFF00 || chg_val[2] !== 32'hFFFFFE00) begin
      n_fail++;
      $display("[TB] FAIL redirect: start=%0h changes=%0d, expected 100 -> 0 -> FFFFFF00 -> FFFFFE00",
               start_val, chg_val.size());
    end
  endtask

  task automatic test_bus();
    logic [31:0] d; logic a;
    @(negedge clk_i);
    addr = 16'h03F0; ren = 1'b1;
    n_checks++;
    if (ack !== 1'b0) begin n_fail++; $display("[TB] FAIL ack_early: ack=%0b, expected 0", ack); end
    @(negedge clk_i);
    ren = 1'b0;
    n_checks++;
    if (ack !== 1'b1 || rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL read_unmapped: ack=%0b rdata=%0h, expected ack=1 rdata=0", ack, rdata); end
    @(negedge clk_i);
    wen = 1'b1; addr = 16'h03F4; wdata = 32'hDEADBEEF;
    @(negedge clk_i);
    wen = 1'b0;
    n_checks++;
    if (ack !== 1'b1 || rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL write_ack: ack=%0b rdata=%0h, expected ack=1 rdata=0", ack, rdata); end
    bus_read(16'h0118, d, a);
    n_checks++;
    if (a !== 1'b1 || d !== 32'd0) begin n_fail++; $display("[TB] FAIL absent_slot: ack=%0b rdata=%0h, expected ack=1 rdata=0", a, d); end
    bus_write(A_CUR0, 32'h1234);
    bus_write(16'h0204, 32'h7);
    bus_read(A_CUR0, d, a);
    n_checks++;
    if (d !== 32'hFFFFFE00) begin n_fail++; $display("[TB] FAIL ro_cur_gain: rdata=%0h, expected FFFFFE00", d); end
    bus_read(16'h0204, d, a);
    n_checks++;
    if (d !== 32'd2) begin n_fail++; $display("[TB] FAIL ro_nch: rdata=%0d, expected 2", d); end
    bus_write(A_STEP, 32'hFFFFFFFF);
    bus_read(A_STEP, d, a);
    n_checks++;
    if (d !== 32'h007FFFFF) begin n_fail++; $display("[TB] FAIL step_width: rdata=%0h, expected 007FFFFF", d); end
    bus_write(A_DIV, 32'hFFFF1234);
    bus_read(A_DIV, d, a);
    n_checks++;
    if (d !== 32'h00001234) begin n_fail++; $display("[TB] FAIL div_width: rdata=%0h, expected 00001234", d); end
    bus_write(A_TGT1, 32'h00800000);
    bus_read(A_TGT1, d, a);
    n_checks++;
    if (d !== 32'hFF800000) begin n_fail++; $display("[TB] FAIL gain_sign_ext: rdata=%0h, expected FF800000", d); end
    bus_write(A_TGT1, 32'h0);
    bus_write(A_STEP, 32'h100);
    bus_write(A_DIV, 32'd9);
  endtask

  task automatic test_reset_mid_ramp();
    logic [31:0] d; logic a;
    set_gains(0, 0, 1'b1);
    bus_write(A_CTRL, 32'h3);
    bus_write(A_TGT0, 32'h001000);
    dat_i = {14'd0, 14'd1000};
    bus_read(A_STATUS, d, a);
    n_checks++;
    if (d[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL ramp_busy_set: STATUS=%0h, expected bit0=1", d); end
    @(negedge clk_i);
    addr = A_CUR0; ren = 1'b1;
    repeat (60) @(negedge clk_i);
    n_checks++;
    if (ack !== 1'b1 || dat_o === 14'd0) begin n_fail++; $display("[TB] FAIL pre_reset_activity: ack=%0b dat_o=%0d, expected ack=1 dat_o!=0", ack, dat_o); end
    #1 rstn_i = 1'b0;
    #1;
    n_checks++;
    if ({dat_o, sat_o, ack, rdata} !== '0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: dat_o=%0h sat_o=%0b ack=%0b rdata=%0h, expected all 0", dat_o, sat_o, ack, rdata);
    end
    ren = 1'b0; dat_i = '0;
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    bus_read(A_CUR0, d, a);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_cur_gain: rdata=%0h, expected 0", d); end
    bus_read(A_TGT0, d, a);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_target: rdata=%0h, expected 0", d); end
    bus_read(A_CTRL, d, a);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_ctrl2: rdata=%0h, expected 0", d); end
    bus_read(A_DIV, d, a);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_div: rdata=%0h, expected 0", d); end
    bus_read(A_STEP, d, a);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_step: rdata=%0h, expected 0", d); end
    bus_read(A_STATUS, d, a);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_status: rdata=%0h, expected 0", d); end
    bus_read(16'h03F0, d, a);
    n_checks++;
    if (a !== 1'b1 || d !== 32'd0) begin n_fail++; $display("[TB] FAIL post_reset_unmapped: ack=%0b rdata=%0h, expected ack=1 rdata=0", a, d); end
    bus_read(16'h0204, d, a);
    n_checks++;
    if (a !== 1'b1 || d !== 32'd2) begin n_fail++; $display("[TB] FAIL post_reset_nch: ack=%0b rdata=%0d, expected ack=1 rdata=2", a, d); end
    n_checks++;
    if (dat_o !== 14'd0 || sat_o !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_output: dat_o=%0d sat_o=%0b, expected 0/0", dat_o, sat_o); end
  endtask

  initial begin
    exp_g0 = 0; exp_g1 = 0; exp_en = 1'b0;
    test_reset();
    test_pass_through();
    test_saturation();
    test_weighted_sum();
    test_enable_off();
    test_ramp();
    test_no_overshoot();
    test_bus();
    test_reset_mid_ramp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
